ui_event_capture: RTL and testbench

Memory-mapped change-detection and status unit for the debounced push-button and slide-switch inputs. It sits between the debouncers and the processor's I/O read/write path, next to the LED/HEX device bank. It latches input changes into sticky ready/overrun flags, so software can poll or take an interrupt instead of sampling raw levels. Reads of a data register acknowledge the pending event.

---
 rtl/ui_event_capture_pkg.sv | 27 ++
 rtl/ui_event_capture_event_channel.sv | 46 ++++
 rtl/ui_event_capture.sv | 79 +++++++
 tb/tb_ui_event_capture.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ui_event_capture_pkg.sv
// Shared register map and control-word layout for the key/switch event capture unit.
package ui_event_capture_pkg;

  typedef enum logic [1:0] {
    RegKdata = 2'd0,
    RegKctrl = 2'd1,
    RegSdata = 2'd2,
    RegSctrl = 2'd3
  } reg_sel_e;

  localparam int unsigned RdyBit    = 0;
  localparam int unsigned OvrBit    = 2;
  localparam int unsigned IeBit     = 8;
  localparam int unsigned CtrlWidth = 9;
  localparam int unsigned KeyWidth  = 4;
  localparam int unsigned SwWidth   = 10;

  function automatic logic [CtrlWidth-1:0] ctrl_word(logic rdy, logic ovr, logic ie);
    logic [CtrlWidth-1:0] w;
    w         = '0;
    w[RdyBit] = rdy;
    w[OvrBit] = ovr;
    w[IeBit]  = ie;
    return w;
  endfunction

endpackage

// File: rtl/ui_event_capture_event_channel.sv
// One change-detection channel: previous level, sticky ready/overrun flags and irq enable.
module ui_event_capture_event_channel #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] level,
  input  logic             data_rd,
  input  logic             ctrl_wr,
  input  logic             wr_ie,
  input  logic             wr_ovr,
  output logic [Width-1:0] prev,
  output logic             rdy,
  output logic             ovr,
  output logic             ie,
  output logic             irq_term
);

  logic change;
  assign change   = (level != prev);
  assign irq_term = rdy & ie;

  always_ff @(negedge clk) begin
    if (reset) begin
      prev <= level;
      rdy  <= 1'b0;
      ovr  <= 1'b0;
      ie   <= 1'b0;
    end else begin
      prev <= level;
      if (ctrl_wr) begin
        ie <= wr_ie;
        if (!wr_ovr) ovr <= 1'b0;
      end
      // A change coinciding with a data read is a fresh event, not an overrun;
      // a genuine overrun overrides a same-cycle ovr clear.
      if (change) begin
        if (rdy && !data_rd) ovr <= 1'b1;
        rdy <= 1'b1;
      end else if (data_rd) begin
        rdy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ui_event_capture.sv
// Memory-mapped change capture for debounced keys and switches: strobe decode and read mux.
module ui_event_capture
  import ui_event_capture_pkg::*;
#(
  parameter int unsigned DBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       keyIn,
  input  logic [9:0]       swIn,
  input  logic             rdEn,
  input  logic             wrtEn,
  input  logic [1:0]       regSel,
  input  logic [DBITS-1:0] in,
  output logic [DBITS-1:0] out,
  output logic             irq
);

  reg_sel_e sel;
  assign sel = reg_sel_e'(regSel);

  logic [KeyWidth-1:0] kprev;
  logic [SwWidth-1:0]  sprev;
  logic krdy, kovr, kie, kirq;
  logic srdy, sovr, sie, sirq;

  logic unused_in;
  assign unused_in = ^{in[DBITS-1:IeBit+1], in[IeBit-1:OvrBit+1], in[OvrBit-1:0]};

  ui_event_capture_event_channel #(
    .Width(KeyWidth)
  ) u_key (
    .clk     (clk),
    .reset   (reset),
    .level   (keyIn),
    .data_rd (rdEn && (sel == RegKdata)),
    .ctrl_wr (wrtEn && (sel == RegKctrl)),
    .wr_ie   (in[IeBit]),
    .wr_ovr  (in[OvrBit]),
    .prev    (kprev),
    .rdy     (krdy),
    .ovr     (kovr),
    .ie      (kie),
    .irq_term(kirq)
  );

  ui_event_capture_event_channel #(
    .Width(SwWidth)
  ) u_sw (
    .clk     (clk),
    .reset   (reset),
    .level   (swIn),
    .data_rd (rdEn && (sel == RegSdata)),
    .ctrl_wr (wrtEn && (sel == RegSctrl)),
    .wr_ie   (in[IeBit]),
    .wr_ovr  (in[OvrBit]),
    .prev    (sprev),
    .rdy     (srdy),
    .ovr     (sovr),
    .ie      (sie),
    .irq_term(sirq)
  );

  assign irq = kirq | sirq;

  always_comb begin
    out = '0;
    if (rdEn) begin
      unique case (sel)
        RegKdata: out[KeyWidth-1:0]  = kprev;
        RegKctrl: out[CtrlWidth-1:0] = ctrl_word(krdy, kovr, kie);
        RegSdata: out[SwWidth-1:0]   = sprev;
        RegSctrl: out[CtrlWidth-1:0] = ctrl_word(srdy, sovr, sie);
        default:  out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ui_event_capture.sv
// Directed bench for ui_event_capture; state changes on the falling clock edge.
module tb_ui_event_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  keyIn;
  logic [9:0]  swIn;
  logic        rdEn;
  logic        wrtEn;
  logic [1:0]  regSel;
  logic [31:0] in;
  logic [31:0] out;
  logic        irq;

  int passes = 0;
  int total  = 0;

  localparam logic [1:0] KDATA = 2'd0, KCTRL = 2'd1, SDATA = 2'd2, SCTRL = 2'd3;

  ui_event_capture #(.DBITS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .keyIn (keyIn),
    .swIn  (swIn),
    .rdEn  (rdEn),
    .wrtEn (wrtEn),
    .regSel(regSel),
    .in    (in),
    .out   (out),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance past one falling edge; inputs may then be changed safely.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Combinational read; commit=1 keeps rdEn through an edge so side effects apply.
  task automatic rd(input logic [1:0] sel, input logic [31:0] exp, input string tag,
                    input bit commit);
    regSel = sel;
    rdEn   = 1'b1;
    #1;
    chk(tag, out, exp);
    if (commit) tick();
    rdEn = 1'b0;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] data);
    regSel = sel;
    in     = data;
    wrtEn  = 1'b1;
    tick();
    wrtEn  = 1'b0;
    in     = '0;
  endtask

  initial begin
    reset = 1'b1; keyIn = 4'hF; swIn = '0; rdEn = 0; wrtEn = 0; regSel = KDATA; in = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("reset_irq", {31'd0, irq}, 32'd0);
    rd(KCTRL, 32'h000, "reset_kctrl", 0);
    rd(SCTRL, 32'h000, "reset_sctrl", 0);
    rd(KDATA, 32'h0000_000F, "reset_kdata", 0);
    regSel = KDATA; #1;
    chk("out_zero_no_rden", out, 32'd0);

    // Key change with irq disabled, then enable, then acknowledge by reading
    keyIn = 4'hE; tick();
    rd(KCTRL, 32'h001, "key_change_kctrl", 0);
    chk("key_change_irq_off", {31'd0, irq}, 32'd0);
    wr(KCTRL, 32'h100);
    chk("kie_irq_on", {31'd0, irq}, 32'd1);
    wr(KDATA, 32'hFFFF_FFFF);
    rd(KCTRL, 32'h101, "kdata_write_ignored", 0);
    rd(KDATA, 32'h0000_000E, "kdata_read", 1);
    chk("irq_after_ack", {31'd0, irq}, 32'd0);
    rd(KCTRL, 32'h100, "kctrl_after_ack", 0);

    // Two switch changes without a read produce an overrun
    swIn = 10'h001; tick();
    swIn = 10'h003; tick();
    rd(SCTRL, 32'h005, "sw_overrun", 0);
    chk("sw_irq_disabled", {31'd0, irq}, 32'd0);
    wr(SCTRL, 32'h000);
    rd(SCTRL, 32'h001, "sw_ovr_clear", 0);
    rd(SDATA, 32'h0000_0003, "sdata_read", 0);

    // Change on the same edge as a data read with rdy=1: fresh event, no overrun
    keyIn = 4'hC; tick();
    rd(KCTRL, 32'h101, "key_rdy_set", 0);
    keyIn = 4'h8;
    rd(KDATA, 32'h0000_000C, "kdata_during_change", 1);
    rd(KCTRL, 32'h101, "change_beats_read", 0);

    // rdy is read-only; writing 1 to ovr keeps it
    rd(KDATA, 32'h0000_0008, "kdata_ack", 1);
    wr(KCTRL, 32'h001);
    rd(KCTRL, 32'h000, "rdy_read_only", 0);
    keyIn = 4'h0; tick();
    keyIn = 4'h1; tick();
    rd(KCTRL, 32'h005, "key_overrun", 0);
    wr(KCTRL, 32'h004);
    rd(KCTRL, 32'h005, "ovr_write_one_keeps", 0);
    wr(KCTRL, 32'h000);
    rd(KCTRL, 32'h001, "ovr_write_zero_clears", 0);

    // New overrun beats a same-cycle ovr clear
    keyIn = 4'h3;
    wr(KCTRL, 32'h000);
    rd(KCTRL, 32'h005, "overrun_beats_clear", 0);

    // Reset overrides pending change and CTRL write
    wr(KCTRL, 32'h104);
    rd(KCTRL, 32'h105, "pre_reset_flags", 0);
    chk("pre_reset_irq", {31'd0, irq}, 32'd1);
    reset = 1'b1; keyIn = 4'h7; regSel = KCTRL; in = 32'h100; wrtEn = 1'b1;
    tick();
    reset = 1'b0; wrtEn = 1'b0; in = '0;
    chk("reset_override_irq", {31'd0, irq}, 32'd0);
    rd(KCTRL, 32'h000, "reset_override_kctrl", 0);
    rd(SCTRL, 32'h000, "reset_override_sctrl", 0);
    tick();
    rd(KCTRL, 32'h000, "no_event_after_reset", 0);
    rd(KDATA, 32'h0000_0007, "prev_after_reset", 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
